// File: rtl/dcache_snoop_agent.sv
// Snooped-side MSI coherence agent for one 2-way L1 dcache: answers controller snoops,
// supplies Modified blocks word by word, then downgrades M->S or invalidates on request.
module dcache_snoop_agent #(
    parameter  int SETS = 8,
    localparam int IDXW = $clog2(SETS),
    localparam int TAGW = 32 - 3 - IDXW
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ccwait,
    input  logic                i_ccinv,
    input  logic [31:0]         i_ccsnoopaddr,
    input  logic                i_dwait,
    output logic                o_cctrans,
    output logic                o_ccwrite,
    output logic [31:0]         o_snp_daddr,
    output logic [31:0]         o_snp_dstore,
    output logic                o_snoop_busy,
    output logic [IDXW-1:0]     o_arr_idx,
    input  logic [2*TAGW-1:0]   i_arr_tag,
    input  logic [3:0]          i_arr_state,
    output logic                o_arr_way,
    output logic                o_arr_word,
    input  logic [31:0]         i_arr_rdata,
    output logic                o_st_wen,
    output logic                o_st_way,
    output logic [IDXW-1:0]     o_st_idx,
    output logic [1:0]          o_st_wdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WB1       = 3'd2;
    localparam logic [2:0] S_WB2       = 3'd3;
    localparam logic [2:0] S_DOWNGRADE = 3'd4;
    localparam logic [2:0] S_INV       = 3'd5;

    localparam logic [1:0] MSI_I = 2'b00;
    localparam logic [1:0] MSI_S = 2'b01;
    localparam logic [1:0] MSI_M = 2'b10;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [TAGW-1:0] r_tag;
    logic [IDXW-1:0] r_idx;
    logic            r_way;

    logic [TAGW-1:0] w_tag0;
    logic [TAGW-1:0] w_tag1;
    logic [1:0]      w_st0;
    logic [1:0]      w_st1;
    logic            w_hit0;
    logic            w_hit1;
    logic            w_hit;
    logic            w_hitway;
    logic            w_hitm;
    logic            w_wb;
    logic [2:0]      w_unused_off;

    // Snoops always address the block base, so the offset bits are dropped.
    assign w_unused_off = i_ccsnoopaddr[2:0];

    assign w_tag0   = i_arr_tag[TAGW-1:0];
    assign w_tag1   = i_arr_tag[2*TAGW-1:TAGW];
    assign w_st0    = i_arr_state[1:0];
    assign w_st1    = i_arr_state[3:2];
    // Encoding 11 is illegal and must never count as a valid line.
    assign w_hit0   = ((w_st0 == MSI_S) || (w_st0 == MSI_M)) && (w_tag0 == r_tag);
    assign w_hit1   = ((w_st1 == MSI_S) || (w_st1 == MSI_M)) && (w_tag1 == r_tag);
    assign w_hit    = w_hit0 | w_hit1;
    assign w_hitway = ~w_hit0;
    assign w_hitm   = w_hit0 ? (w_st0 == MSI_M) : (w_hit1 && (w_st1 == MSI_M));

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (i_ccwait)
                    w_next = i_ccinv ? S_INV : S_LOOKUP;
            end
            S_LOOKUP: begin
                if (i_ccwait && w_hitm)
                    w_next = S_WB1;
            end
            S_WB1: begin
                if (!i_ccwait)
                    w_next = S_IDLE;
                else if (!i_dwait)
                    w_next = S_WB2;
                else
                    w_next = S_WB1;
            end
            S_WB2: begin
                if (!i_ccwait)
                    w_next = S_IDLE;
                else if (!i_dwait)
                    w_next = S_DOWNGRADE;
                else
                    w_next = S_WB2;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_tag   <= '0;
            r_idx   <= '0;
            r_way   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_ccwait) begin
                r_tag <= i_ccsnoopaddr[31:32-TAGW];
                r_idx <= i_ccsnoopaddr[3+IDXW-1:3];
            end
            if (r_state == S_LOOKUP)
                r_way <= w_hitway;
        end
    end

    assign w_wb = (r_state == S_WB1) || (r_state == S_WB2);

    // Reset gating keeps every output low while reset is asserted, even if ccwait is high.
    assign o_snoop_busy = i_rst_n & ((r_state != S_IDLE) | i_ccwait);
    assign o_cctrans    = (r_state == S_LOOKUP) | w_wb;
    assign o_ccwrite    = ((r_state == S_LOOKUP) & w_hitm) | w_wb;
    assign o_snp_daddr  = w_wb ? {r_tag, r_idx, (r_state == S_WB2), 2'b00} : 32'h0;
    assign o_snp_dstore = w_wb ? i_arr_rdata : 32'h0;

    assign o_arr_idx    = r_idx;
    assign o_arr_way    = r_way;
    assign o_arr_word   = (r_state == S_WB2);

    assign o_st_idx     = r_idx;
    assign o_st_wen     = (r_state == S_DOWNGRADE) | ((r_state == S_INV) & w_hit);
    assign o_st_way     = (r_state == S_DOWNGRADE) ? r_way :
                          (r_state == S_INV)       ? (w_hit & w_hitway) : 1'b0;
    assign o_st_wdata   = (r_state == S_DOWNGRADE) ? MSI_S : MSI_I;

endmodule

// File: tb/tb_dcache_snoop_agent.sv
// Directed bench for dcache_snoop_agent: an array model answers lookups, and a scoreboard queue
// holds the expected output snapshot for every cycle, checked on the falling edge.
module tb_dcache_snoop_agent;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ccwait;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
    logic        dwait;
    logic        cctrans;
    logic        ccwrite;
    logic [31:0] snp_daddr;
    logic [31:0] snp_dstore;
    logic        snoop_busy;
    logic [2:0]  arr_idx;
    logic [51:0] arr_tag;
    logic [3:0]  arr_state;
    logic        arr_way;
    logic        arr_word;
    logic [31:0] arr_rdata;
    logic        st_wen;
    logic        st_way;
    logic [2:0]  st_idx;
    logic [1:0]  st_wdata;

    always #5 clk = ~clk;

    dcache_snoop_agent #(.SETS(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ccwait(ccwait), .i_ccinv(ccinv),
        .i_ccsnoopaddr(ccsnoopaddr), .i_dwait(dwait),
        .o_cctrans(cctrans), .o_ccwrite(ccwrite), .o_snp_daddr(snp_daddr),
        .o_snp_dstore(snp_dstore), .o_snoop_busy(snoop_busy), .o_arr_idx(arr_idx),
        .i_arr_tag(arr_tag), .i_arr_state(arr_state), .o_arr_way(arr_way),
        .o_arr_word(arr_word), .i_arr_rdata(arr_rdata), .o_st_wen(st_wen),
        .o_st_way(st_way), .o_st_idx(st_idx), .o_st_wdata(st_wdata)
    );

    // Cache array model: tags/data loaded directly, state updated only on the clock edge.
    logic [25:0] mtag [8][2];
    logic [31:0] mdat [8][2][2];
    logic [1:0]  mst  [8][2] = '{default: 2'b00};
    logic        ldEn = 1'b0;
    logic [2:0]  ldIdx = 3'd0;
    logic        ldWay = 1'b0;
    logic [1:0]  ldState = 2'b00;

    always_comb begin
        arr_tag   = {mtag[arr_idx][1], mtag[arr_idx][0]};
        arr_state = {mst[arr_idx][1], mst[arr_idx][0]};
        arr_rdata = mdat[arr_idx][arr_way][arr_word];
    end

    always @(posedge clk) begin
        if (ldEn)
            mst[ldIdx][ldWay] <= ldState;
        if (st_wen)
            mst[st_idx][st_way] <= st_wdata;
    end

    logic [73:0] expq [$];
    string       tagq [$];
    logic [73:0] obsVec;
    logic [73:0] curExp;
    string       curTag;
    int          vectors = 0;
    int          miscompares = 0;

    assign obsVec = {snoop_busy, cctrans, ccwrite, snp_daddr, snp_dstore,
                     st_wen, st_way, st_idx, st_wdata};

    always @(negedge clk) begin
        if (expq.size() != 0) begin
            curExp = expq.pop_front();
            curTag = tagq.pop_front();
            vectors++;
            assert (obsVec === curExp) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %h expected %h", curTag, obsVec, curExp);
            end
        end
    end

    function automatic logic [73:0] ev(input logic busy, input logic tr, input logic wr,
                                       input logic [31:0] da, input logic [31:0] ds,
                                       input logic wen, input logic way,
                                       input logic [2:0] idx, input logic [1:0] wd);
        return {busy, tr, wr, da, ds, wen, way, idx, wd};
    endfunction

    task automatic step(input string tag, input logic [73:0] e);
        expq.push_back(e);
        tagq.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $error("[TB] FAIL %s: busy=%b trans=%b write=%b daddr=%h dstore=%h wen=%b",
                   tag, snoop_busy, cctrans, ccwrite, snp_daddr, snp_dstore, st_wen);
        end
    endtask

    task automatic loadLine(input logic [2:0] idx, input logic way, input logic [25:0] tg,
                            input logic [1:0] st, input logic [31:0] d0, input logic [31:0] d1);
        mtag[idx][way]    = tg;
        mdat[idx][way][0] = d0;
        mdat[idx][way][1] = d1;
        ldIdx   = idx;
        ldWay   = way;
        ldState = st;
        ldEn    = 1'b1;
        @(posedge clk);
        #1;
        ldEn = 1'b0;
    endtask

    localparam logic [31:0] Z = 32'h0;

    initial begin
        for (int i = 0; i < 8; i++)
            for (int w = 0; w < 2; w++) begin
                mtag[i][w]    = 26'h0;
                mdat[i][w][0] = 32'h0;
                mdat[i][w][1] = 32'h0;
            end
        rst_n = 1'b0;
        ccwait = 1'b0;
        ccinv = 1'b0;
        ccsnoopaddr = 32'h0;
        dwait = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_state", (cctrans === 1'b0) && (ccwrite === 1'b0) &&
                                   (snoop_busy === 1'b0) && (st_wen === 1'b0) &&
                                   (snp_daddr === 32'h0) && (snp_dstore === 32'h0));
        step("reset_hold", ev(0, 0, 0, Z, Z, 0, 0, 3'd0, 2'b00));
        rst_n = 1'b1;
        step("reset_idle", ev(0, 0, 0, Z, Z, 0, 0, 3'd0, 2'b00));

        // Miss: all lines invalid
        ccwait = 1'b1; ccsnoopaddr = 32'h0000_1050;
        step("miss_capture", ev(1, 0, 0, Z, Z, 0, 0, 3'd0, 2'b00));
        ccwait = 1'b0;
        step("miss_lookup",  ev(1, 1, 0, Z, Z, 0, 0, 3'd2, 2'b00));
        step("miss_idle",    ev(0, 0, 0, Z, Z, 0, 0, 3'd2, 2'b00));

        // Shared hit in way0
        loadLine(3'd2, 1'b0, 26'h41, 2'b01, 32'h1111_1111, 32'h2222_2222);
        ccwait = 1'b1;
        step("shit_capture", ev(1, 0, 0, Z, Z, 0, 0, 3'd2, 2'b00));
        ccwait = 1'b0;
        step("shit_lookup",  ev(1, 1, 0, Z, Z, 0, 0, 3'd2, 2'b00));
        step("shit_idle",    ev(0, 0, 0, Z, Z, 0, 0, 3'd2, 2'b00));

        // Modified hit in way1, with a 5-cycle dwait stall on the first word
        loadLine(3'd2, 1'b0, 26'h41, 2'b00, 32'h0, 32'h0);
        loadLine(3'd2, 1'b1, 26'h41, 2'b10, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        ccwait = 1'b1; ccsnoopaddr = 32'h0000_1054; dwait = 1'b1;
        step("m_capture", ev(1, 0, 0, Z, Z, 0, 0, 3'd2, 2'b00));
        step("m_lookup",  ev(1, 1, 1, Z, Z, 0, 0, 3'd2, 2'b00));
        for (int k = 0; k < 5; k++)
            step("m_wb1_stall", ev(1, 1, 1, 32'h0000_1050, 32'hDEAD_BEEF, 0, 0, 3'd2, 2'b00));
        dwait = 1'b0;
        step("m_wb1_accept", ev(1, 1, 1, 32'h0000_1050, 32'hDEAD_BEEF, 0, 0, 3'd2, 2'b00));
        step("m_wb2",        ev(1, 1, 1, 32'h0000_1054, 32'hCAFE_F00D, 0, 0, 3'd2, 2'b00));
        ccwait = 1'b0;
        step("m_downgrade",  ev(1, 0, 0, Z, Z, 1, 1, 3'd2, 2'b01));
        step("m_idle",       ev(0, 0, 0, Z, Z, 0, 0, 3'd2, 2'b00));

        // Same block again: now Shared, so no data follows
        ccwait = 1'b1; ccsnoopaddr = 32'h0000_1050;
        step("post_dg_capture", ev(1, 0, 0, Z, Z, 0, 0, 3'd2, 2'b00));
        ccwait = 1'b0;
        step("post_dg_lookup",  ev(1, 1, 0, Z, Z, 0, 0, 3'd2, 2'b00));
        step("post_dg_idle",    ev(0, 0, 0, Z, Z, 0, 0, 3'd2, 2'b00));

        // Invalidate: hit on Modified way0 at idx5, then the same address misses
        loadLine(3'd5, 1'b0, 26'h7, 2'b10, 32'h5555_0000, 32'h5555_0001);
        ccwait = 1'b1; ccinv = 1'b1; ccsnoopaddr = 32'h0000_01E8;
        step("inv_capture", ev(1, 0, 0, Z, Z, 0, 0, 3'd2, 2'b00));
        ccwait = 1'b0; ccinv = 1'b0;
        step("inv_hit",     ev(1, 0, 0, Z, Z, 1, 0, 3'd5, 2'b00));
        step("inv_idle",    ev(0, 0, 0, Z, Z, 0, 0, 3'd5, 2'b00));
        ccwait = 1'b1; ccinv = 1'b1;
        step("invm_capture", ev(1, 0, 0, Z, Z, 0, 0, 3'd5, 2'b00));
        ccwait = 1'b0; ccinv = 1'b0;
        step("inv_miss",     ev(1, 0, 0, Z, Z, 0, 0, 3'd5, 2'b00));
        step("invm_idle",    ev(0, 0, 0, Z, Z, 0, 0, 3'd5, 2'b00));

        // Back-to-back snoops: ccwait stays high across the return to IDLE
        ccwait = 1'b1; ccsnoopaddr = 32'h0000_1050;
        step("b2b_capture1", ev(1, 0, 0, Z, Z, 0, 0, 3'd5, 2'b00));
        ccsnoopaddr = 32'h0000_01E8;
        step("b2b_lookup1",  ev(1, 1, 0, Z, Z, 0, 0, 3'd2, 2'b00));
        step("b2b_capture2", ev(1, 0, 0, Z, Z, 0, 0, 3'd2, 2'b00));
        ccwait = 1'b0;
        step("b2b_lookup2",  ev(1, 1, 0, Z, Z, 0, 0, 3'd5, 2'b00));
        step("b2b_idle",     ev(0, 0, 0, Z, Z, 0, 0, 3'd5, 2'b00));

        // Asynchronous reset during WB2 aborts without a state write
        loadLine(3'd2, 1'b1, 26'h41, 2'b10, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        ccwait = 1'b1; ccsnoopaddr = 32'h0000_1050; dwait = 1'b0;
        step("rst_capture", ev(1, 0, 0, Z, Z, 0, 0, 3'd5, 2'b00));
        step("rst_lookup",  ev(1, 1, 1, Z, Z, 0, 0, 3'd2, 2'b00));
        step("rst_wb1",     ev(1, 1, 1, 32'h0000_1050, 32'hDEAD_BEEF, 0, 0, 3'd2, 2'b00));
        rst_n = 1'b0;
        step("rst_in_wb2",  ev(0, 0, 0, Z, Z, 0, 0, 3'd0, 2'b00));
        rst_n = 1'b1; ccwait = 1'b0;
        step("rst_release1", ev(0, 0, 0, Z, Z, 0, 0, 3'd0, 2'b00));
        step("rst_release2", ev(0, 0, 0, Z, Z, 0, 0, 3'd0, 2'b00));

        // Line must still be Modified; ccwait dropping in LOOKUP aborts the supply
        ccwait = 1'b1;
        step("abort_capture", ev(1, 0, 0, Z, Z, 0, 0, 3'd0, 2'b00));
        ccwait = 1'b0;
        step("abort_lookup",  ev(1, 1, 1, Z, Z, 0, 0, 3'd2, 2'b00));
        checkOutput("expired_wait", (snoop_busy === 1'b0) && (cctrans === 1'b0) &&
                                    (ccwrite === 1'b0) && (st_wen === 1'b0));
        step("abort_idle",    ev(0, 0, 0, Z, Z, 0, 0, 3'd2, 2'b00));
        step("abort_idle2",   ev(0, 0, 0, Z, Z, 0, 0, 3'd2, 2'b00));

        @(negedge clk);
        #1;
        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
